// File: rtl/adpcm_pkg.sv
// Shared ADPCM codec widths and constants for the speed-control filters.
package adpcm_pkg;

  localparam int WFI       = 3;   // F(I) weighting width
  localparam int WDML      = 14;  // long-term average width
  localparam int WDIF      = 15;  // difference width, MSB is the sign
  localparam int SHIFT_FI  = 11;  // FI is aligned to DML's scale
  localparam int SHIFT_DIF = 7;   // 2^-7 adaptation gain

  // Sign-extension pattern for the shifted 8-bit difference
  localparam logic [WDML-1:0] SGNX = 14'h3F00;

  typedef logic [WFI-1:0]  fi_t;
  typedef logic [WDML-1:0] dml_t;
  typedef logic [WDIF-1:0] dif_t;

endpackage

// File: rtl/filtb_core.sv
// Combinational FILTB datapath: FI, DML -> DML + ((FI<<11) - DML) * 2^-7.
module filtb_core
  import adpcm_pkg::*;
(
  input  logic [WFI-1:0]  fi,
  input  logic [WDML-1:0] dml,
  output logic [WDML-1:0] dmlp_next
);

  dml_t fis;
  dif_t dif;
  logic difs;
  dml_t difsx;

  // Scaled difference, arithmetic shift by 7, and modular accumulate
  always_comb begin
    fis       = dml_t'(fi) << SHIFT_FI;
    // 15-bit subtraction wraps exactly like (FIS + 32768 - DML) mod 32768
    dif       = {1'b0, fis} - {1'b0, dml};
    difs      = dif[WDIF-1];
    difsx     = dml_t'(dif >> SHIFT_DIF);
    if (difs) difsx = difsx | SGNX;
    // Carry out of the 14-bit add is dropped on purpose
    dmlp_next = difsx + dml;
  end

endmodule

// File: rtl/filtb.sv
// FILTB adaptation-speed filter: combinational core plus one output register.
module filtb
  import adpcm_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [WFI-1:0]  FI,
  input  logic [WDML-1:0] DML,
  output logic [WDML-1:0] DMLP
);

  dml_t dmlp_d;
  dml_t dmlp_q;

  filtb_core u_core (
    .fi        (FI),
    .dml       (DML),
    .dmlp_next (dmlp_d)
  );

  // Output register; reset overrides the update
  always_ff @(posedge clk) begin
    if (reset) dmlp_q <= '0;
    else       dmlp_q <= dmlp_d;
  end

  assign DMLP = dmlp_q;

endmodule

// File: tb/tb_filtb.sv
// Bench for filtb: directed codec cases plus a randomized sweep against a model.
module tb_filtb;

  logic        clk;
  logic        reset;
  logic [2:0]  FI;
  logic [13:0] DML;
  logic [13:0] DMLP;

  int total = 0;
  int bad   = 0;

  filtb dut (
    .clk   (clk),
    .reset (reset),
    .FI    (FI),
    .DML   (DML),
    .DMLP  (DMLP)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: long-term average update in plain integer arithmetic
  function automatic int model(input bit rst, input int fi, input int dml);
    int diff, step;
    if (rst) return 0;
    diff = fi * 2048 - dml;            // signed difference, range -16383..14336
    step = (diff + 32768) % 32768;     // 15-bit wrapped form
    step = step / 128;
    if (diff < 0) step = step + 16128; // negative: upper six bits set
    return (dml + step) % 16384;
  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Apply inputs away from the edge, clock once, sample just after the edge
  task automatic step(input bit r, input int fi, input int dml, input string tag);
    @(negedge clk);
    reset = r;
    FI    = 3'(fi);
    DML   = 14'(dml);
    @(posedge clk);
    #1;
    chk(tag, int'(DMLP), model(r, fi, dml));
  endtask

  initial begin
    int held;
    bit r;
    int fi, dml;
    reset = 1'b1;
    FI    = '0;
    DML   = '0;

    // Directed cases with hand-derived expectations
    step(1'b1, 5, 9999, "reset");
    chk("reset_const", int'(DMLP), 0);
    step(1'b0, 0, 0, "zero");
    chk("zero_const", int'(DMLP), 0);
    step(1'b0, 7, 0, "fi7_dml0");
    chk("fi7_dml0_const", int'(DMLP), 112);
    step(1'b0, 0, 16383, "neg_wrap");
    chk("neg_wrap_const", int'(DMLP), 16255);
    step(1'b0, 1, 100, "fi1_dml100");
    chk("fi1_dml100_const", int'(DMLP), 115);
    step(1'b0, 3, 6144, "fixed_pt");
    chk("fixed_pt_const", int'(DMLP), 6144);

    // Mid-cycle input changes must not reach the registered output
    held = int'(DMLP);
    #2;
    FI  = 3'd7;
    DML = 14'd1;
    #1;
    chk("glitch_hold", int'(DMLP), held);

    // Mid-stream reset, then resume from current inputs
    step(1'b0, 6, 200, "pre_rst");
    step(1'b1, 6, 200, "mid_rst");
    step(1'b0, 6, 200, "post_rst");
    step(1'b0, 2, 4096, "fixed_pt2");

    // Random sweep; reset pulsed occasionally, stop at first mismatch
    for (int i = 0; i < 10000; i++) begin
      r   = ($urandom_range(0, 49) == 0);
      fi  = int'($urandom_range(0, 7));
      dml = int'($urandom_range(0, 16383));
      step(r, fi, dml, "rand");
      if (bad != 0) break;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
